// File: rtl/q_writeback_if.sv
// Handshake, update payload and BRAM port bundle for the Q-learning writeback stage.
// The slave modport is the writeback block; the master modport is the pipeline/BRAM side.
interface q_writeback_if #(
    parameter int STATE_WIDTH  = 6,
    parameter int ACTION_WIDTH = 2,
    parameter int SUM_WIDTH    = 24,
    parameter int DATA_WIDTH   = 8
);
    logic                                i_valid;
    logic                                o_ready;
    logic [STATE_WIDTH-1:0]              i_state;
    logic [ACTION_WIDTH-1:0]             i_action;
    logic [SUM_WIDTH-1:0]                i_sum;
    logic [STATE_WIDTH+ACTION_WIDTH-1:0] o_q_addr;
    logic                                o_q_we;
    logic [DATA_WIDTH-1:0]               o_q_wdata;
    logic [STATE_WIDTH-1:0]              o_qmax_addr;
    logic                                o_qmax_we;
    logic [DATA_WIDTH-1:0]               o_qmax_wdata;
    logic [DATA_WIDTH-1:0]               i_qmax_rdata;
    logic                                o_done;
    logic                                o_qmax_upd;

    modport slave (
        input  i_valid, i_state, i_action, i_sum, i_qmax_rdata,
        output o_ready, o_q_addr, o_q_we, o_q_wdata,
               o_qmax_addr, o_qmax_we, o_qmax_wdata, o_done, o_qmax_upd
    );

    modport master (
        output i_valid, i_state, i_action, i_sum, i_qmax_rdata,
        input  o_ready, o_q_addr, o_q_we, o_q_wdata,
               o_qmax_addr, o_qmax_we, o_qmax_wdata, o_done, o_qmax_upd
    );
endinterface

// File: rtl/q_writeback.sv
// Q-learning writeback: round/saturate the Q12.12 sum to Q4.4, write Q[s,a], and
// read-compare-write Qmax[s] so it tracks the largest value ever written for s.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for an update; o_done pulses here after a commit
// WR_Q    | Q table write strobe high, Qmax read issued at s
// CMP     | Qmax read data valid, compare against q_new
// WR_QMAX | Qmax table write strobe high with q_new
module q_writeback #(
    parameter int STATE_WIDTH  = 6,
    parameter int ACTION_WIDTH = 2,
    parameter int SUM_WIDTH    = 24,
    parameter int FRAC_IN      = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int FRAC_OUT     = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    q_writeback_if.slave  bus
);
    localparam int SHIFT = FRAC_IN - FRAC_OUT;
    localparam int TW    = SUM_WIDTH - SHIFT + 1;
    localparam int AW    = STATE_WIDTH + ACTION_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_Q    = 2'd1,
        CMP     = 2'd2,
        WR_QMAX = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   q_new_q, q_new_d;
    logic [AW-1:0]           q_addr_q, q_addr_d;
    logic                    q_we_q, q_we_d;
    logic [STATE_WIDTH-1:0]  qmax_addr_q, qmax_addr_d;
    logic                    qmax_we_q, qmax_we_d;
    logic [DATA_WIDTH-1:0]   qmax_wdata_q, qmax_wdata_d;
    logic                    done_q, done_d;
    logic                    upd_q, upd_d;

    logic [TW-1:0]           t_round;
    logic [DATA_WIDTH-1:0]   q_conv;
    logic                    unused_sum_lsbs;

    // One extra bit on the rounded value keeps the round-up carry from wrapping.
    always_comb begin
        t_round = {1'b0, bus.i_sum[SUM_WIDTH-1:SHIFT]} + TW'(bus.i_sum[SHIFT-1]);
        q_conv  = (|t_round[TW-1:DATA_WIDTH]) ? '1 : t_round[DATA_WIDTH-1:0];
    end

    assign unused_sum_lsbs = ^bus.i_sum[SHIFT-2:0];

    always_comb begin
        state_d      = state_q;
        q_new_d      = q_new_q;
        q_addr_d     = q_addr_q;
        q_we_d       = 1'b0;
        qmax_addr_d  = qmax_addr_q;
        qmax_we_d    = 1'b0;
        qmax_wdata_d = qmax_wdata_q;
        done_d       = 1'b0;
        upd_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    q_new_d     = q_conv;
                    q_addr_d    = {bus.i_state, bus.i_action};
                    qmax_addr_d = bus.i_state;
                    q_we_d      = 1'b1;
                    state_d     = WR_Q;
                end
            end
            WR_Q: begin
                state_d = CMP;
            end
            CMP: begin
                // Equal values leave Qmax untouched.
                if (q_new_q > bus.i_qmax_rdata) begin
                    qmax_we_d    = 1'b1;
                    qmax_wdata_d = q_new_q;
                    state_d      = WR_QMAX;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_QMAX: begin
                done_d  = 1'b1;
                upd_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            q_new_q      <= '0;
            q_addr_q     <= '0;
            q_we_q       <= 1'b0;
            qmax_addr_q  <= '0;
            qmax_we_q    <= 1'b0;
            qmax_wdata_q <= '0;
            done_q       <= 1'b0;
            upd_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_new_q      <= q_new_d;
            q_addr_q     <= q_addr_d;
            q_we_q       <= q_we_d;
            qmax_addr_q  <= qmax_addr_d;
            qmax_we_q    <= qmax_we_d;
            qmax_wdata_q <= qmax_wdata_d;
            done_q       <= done_d;
            upd_q        <= upd_d;
        end
    end

    assign bus.o_ready      = (state_q == IDLE);
    assign bus.o_q_addr     = q_addr_q;
    assign bus.o_q_we       = q_we_q;
    assign bus.o_q_wdata    = q_new_q;
    assign bus.o_qmax_addr  = qmax_addr_q;
    assign bus.o_qmax_we    = qmax_we_q;
    assign bus.o_qmax_wdata = qmax_wdata_q;
    assign bus.o_done       = done_q;
    assign bus.o_qmax_upd   = upd_q;
endmodule

// File: tb/tb_q_writeback.sv
// Directed and randomized bench for q_writeback with behavioural Q/Qmax BRAMs
// and a reference model of both tables.
module tb_q_writeback;
    logic i_clk;
    logic i_rst_n;

    q_writeback_if #(.STATE_WIDTH(6), .ACTION_WIDTH(2), .SUM_WIDTH(24), .DATA_WIDTH(8)) bus ();

    q_writeback dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [7:0] q_mem    [256];
    logic [7:0] qmax_mem [64];
    logic [7:0] q_ref    [256];
    logic [7:0] qmax_ref [64];

    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;
    logic       pre_q;

    int n_vec  = 0;
    int n_miss = 0;
    int overlap_cnt = 0;

    always @(posedge i_clk) begin
        if (pre_we && pre_q) q_mem[pre_addr] <= pre_data;
        else if (bus.o_q_we) q_mem[bus.o_q_addr] <= bus.o_q_wdata;
        if (pre_we && !pre_q) qmax_mem[pre_addr[5:0]] <= pre_data;
        else if (bus.o_qmax_we) qmax_mem[bus.o_qmax_addr] <= bus.o_qmax_wdata;
        bus.i_qmax_rdata <= qmax_mem[bus.o_qmax_addr];
    end

    always @(negedge i_clk) begin
        if (bus.o_q_we && bus.o_qmax_we) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_q(input logic [23:0] sum);
        int t;
        t = (int'(sum) + 128) >>> 8;
        return (t > 255) ? 8'hFF : t[7:0];
    endfunction

    task automatic preload(input logic is_q, input logic [7:0] addr, input logic [7:0] data);
        @(negedge i_clk);
        pre_we = 1'b1; pre_q = is_q; pre_addr = addr; pre_data = data;
        @(negedge i_clk);
        pre_we = 1'b0;
        if (is_q) q_ref[addr] = data;
        else      qmax_ref[addr[5:0]] = data;
    endtask

    // Called #1 after the acceptance edge; c counts cycles since acceptance.
    task automatic watch(output int lat, output int qc, output int qmc,
                         output logic [7:0] qa, output logic [7:0] qd,
                         output logic [5:0] qma, output logic [7:0] qmd,
                         output logic upd, output logic [7:0] rd);
        lat = 0; qc = 0; qmc = 0; qa = 0; qd = 0; qma = 0; qmd = 0; upd = 0; rd = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge i_clk);
                #1;
            end
            if (bus.o_q_we) begin qc++; qa = bus.o_q_addr; qd = bus.o_q_wdata; end
            if (bus.o_qmax_we) begin qmc++; qma = bus.o_qmax_addr; qmd = bus.o_qmax_wdata; end
            if (c == 2) rd = bus.i_qmax_rdata;
            if (bus.o_done) begin
                lat = c;
                upd = bus.o_qmax_upd;
                break;
            end
        end
    endtask

    task automatic verify(input logic [5:0] s, input logic [1:0] a, input logic [7:0] exp_q,
                          input logic exp_upd, input logic [7:0] exp_rd,
                          input int lat, input int qc, input int qmc,
                          input logic [7:0] qa, input logic [7:0] qd,
                          input logic [5:0] qma, input logic [7:0] qmd,
                          input logic upd, input logic [7:0] rd);
        check("q_we_count", qc, 1);
        check("q_addr", qa, {s, a});
        check("q_wdata", qd, exp_q);
        check("qmax_rdata", rd, exp_rd);
        check("qmax_we_count", qmc, exp_upd ? 1 : 0);
        if (exp_upd) begin
            check("qmax_addr", qma, s);
            check("qmax_wdata", qmd, exp_q);
        end
        check("latency", lat, exp_upd ? 4 : 3);
        check("qmax_upd", upd, exp_upd);
        q_ref[{s, a}] = exp_q;
        if (exp_upd) qmax_ref[s] = exp_q;
    endtask

    task automatic run_update(input logic [5:0] s, input logic [1:0] a, input logic [23:0] sum,
                              input logic [7:0] exp_q, input logic exp_upd);
        int lat, qc, qmc;
        logic [7:0] qa, qd, qmd, rd;
        logic [5:0] qma;
        logic upd;
        logic [7:0] prev_max;
        prev_max = qmax_ref[s];
        @(negedge i_clk);
        check("ready_idle", bus.o_ready, 1);
        bus.i_valid = 1'b1; bus.i_state = s; bus.i_action = a; bus.i_sum = sum;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        watch(lat, qc, qmc, qa, qd, qma, qmd, upd, rd);
        verify(s, a, exp_q, exp_upd, prev_max, lat, qc, qmc, qa, qd, qma, qmd, upd, rd);
    endtask

    initial begin
        int lat, qc, qmc;
        logic [7:0] qa, qd, qmd, rd;
        logic [5:0] qma;
        logic upd;
        logic [5:0] rs;
        logic [1:0] ra;
        logic [23:0] rsum;
        logic [7:0] eq;

        i_rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_state = '0; bus.i_action = '0; bus.i_sum = '0;
        pre_we = 1'b0; pre_q = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 256; i++) begin
            preload(1'b1, 8'(i), 8'h00);
            if (i < 64) preload(1'b0, 8'(i), 8'h00);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("rst_ready", bus.o_ready, 1);
        check("rst_q_we", bus.o_q_we, 0);
        check("rst_qmax_we", bus.o_qmax_we, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_upd", bus.o_qmax_upd, 0);
        check("rst_q_addr", bus.o_q_addr, 0);
        check("rst_q_wdata", bus.o_q_wdata, 0);

        // Basic update and no-update / equality cases
        preload(1'b0, 8'd5, 8'h20);
        preload(1'b0, 8'd3, 8'h40);
        run_update(6'd5, 2'd2, 24'h003480, 8'h35, 1'b1);
        run_update(6'd3, 2'd1, 24'h001000, 8'h10, 1'b0);
        run_update(6'd3, 2'd1, 24'h004000, 8'h40, 1'b0);

        // Rounding and saturation boundaries
        run_update(6'd9,  2'd0, 24'h00127F, 8'h12, 1'b1);
        run_update(6'd9,  2'd1, 24'h001280, 8'h13, 1'b1);
        run_update(6'd10, 2'd0, 24'h00FF80, 8'hFF, 1'b1);
        run_update(6'd11, 2'd0, 24'h120000, 8'hFF, 1'b1);

        // Held i_valid, back-to-back updates to state 7
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_state = 6'd7; bus.i_action = 2'd0; bus.i_sum = 24'h003000;
        @(posedge i_clk);
        #1;
        check("bp_ready_busy", bus.o_ready, 0);
        bus.i_action = 2'd3; bus.i_sum = 24'h005000;
        watch(lat, qc, qmc, qa, qd, qma, qmd, upd, rd);
        check("bp_ready_on_done", bus.o_ready, 1);
        verify(6'd7, 2'd0, 8'h30, 1'b1, 8'h00, lat, qc, qmc, qa, qd, qma, qmd, upd, rd);
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        watch(lat, qc, qmc, qa, qd, qma, qmd, upd, rd);
        verify(6'd7, 2'd3, 8'h50, 1'b1, 8'h30, lat, qc, qmc, qa, qd, qma, qmd, upd, rd);
        @(negedge i_clk);
        check("bp_qmax7", qmax_mem[7], 8'h50);

        // Reset during CMP aborts the Qmax write and the done pulse
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_state = 6'd12; bus.i_action = 2'd0; bus.i_sum = 24'h002000;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        check("abort_q_we", bus.o_q_we, 1);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        check("abort_qmax_we", bus.o_qmax_we, 0);
        check("abort_done", bus.o_done, 0);
        check("abort_ready", bus.o_ready, 1);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("abort_qmax_we2", bus.o_qmax_we, 0);
        check("abort_done2", bus.o_done, 0);
        check("abort_ready2", bus.o_ready, 1);
        q_ref[{6'd12, 2'd0}] = 8'h20;
        check("abort_qmax12", qmax_mem[12], 8'h00);
        run_update(6'd12, 2'd1, 24'h001000, 8'h10, 1'b1);

        // Random soak from a cleared Qmax table
        for (int i = 0; i < 64; i++) preload(1'b0, 8'(i), 8'h00);
        for (int n = 0; n < 1000; n++) begin
            rs = 6'($urandom_range(0, 63));
            ra = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rsum = 24'($urandom);
            else rsum = 24'($urandom_range(0, 24'h00FFFF));
            eq = model_q(rsum);
            run_update(rs, ra, rsum, eq, eq > qmax_ref[rs]);
        end

        @(negedge i_clk);
        @(negedge i_clk);
        for (int i = 0; i < 256; i++) check("q_table", q_mem[i], q_ref[i]);
        for (int i = 0; i < 64; i++) check("qmax_table", qmax_mem[i], qmax_ref[i]);
        check("we_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
